msrv32_img_pipe: RTL and testbench
==================================

// Module: msrv32_img_pipe
// PURPOSE
//  Pipelined, parametrised immediate generator sitting between decode and the register-read stage.
//  Decodes the immediate for each accepted instruction and sign-extends it to XLEN.
//  Holds results, with a sideband tag, in a DEPTH-entry FIFO so a stalled consumer never blocks decode.
//  Provides valid/ready handshakes on both sides and a synchronous flush for redirects.
// PARAMETERS
//  XLEN   32  immediate output width; legal values 32 or 64
//  DEPTH  2   FIFO entries; power of two, >= 2
//  TAG_W  32  sideband width (PC/rd), carried unmodified alongside the immediate
// PORTS
//  clk_in        in   1          clock, rising edge
//  rst_n_in      in   1          asynchronous active-low reset
//  flush_in      in   1          synchronous flush; empties the FIFO
//  valid_in      in   1          instr_in/imm_type_in/tag_in valid
//  ready_out     out  1          FIFO can accept; equals !full
//  instr_in      in   25         instruction bits [31:7]
//  imm_type_in   in   3          0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR, 7 reserved
//  tag_in        in   TAG_W      sideband
//  valid_out     out  1          head entry valid; equals !empty
//  ready_in      in   1          consumer accepts head entry
//  imm_out       out  XLEN       head immediate
//  imm_type_out  out  3          head type
//  tag_out       out  TAG_W      head sideband
//  count_out     out  log2(DEPTH)+1  occupancy
// BEHAVIOUR
//  Reset: FIFO empty; valid_out=0, count_out=0, imm_out/imm_type_out/tag_out=0, ready_out=1.
//  Decode is combinational on the input side and written into the FIFO on push = valid_in & ready_out.
//  Pop = valid_out & ready_in. Outputs are driven directly from the head entry.
//  Latency: an entry pushed at edge N is visible on valid_out after edge N; there is no fall-through.
//  Push and pop in the same cycle: count is unchanged. When full, push cannot occur because ready_out=0.
//  Write and read pointers wrap modulo DEPTH; count_out saturates at neither end because handshakes prevent it.
//  flush_in: both pointers and count go to 0 at the next edge, with priority over any push or pop in that cycle.
//    The input presented in the flush cycle is dropped.
//  Immediate forms, with s = instr[31] replicated to XLEN:
//    R and I: s, instr[31:20]
//    S: s, instr[31:25], instr[11:7]
//    B: s, instr[31], instr[7], instr[30:25], instr[11:8], 0
//    U: s(XLEN-32 bits), instr[31:12], 12'h0 (RV64 LUI semantics)
//    J: s, instr[31], instr[19:12], instr[20], instr[30:21], 0
//    CSR: zero-extended instr[19:15]
//  Reset asserted mid-operation clears all state immediately; in-flight entries are lost.
// CONFIGURATION
//  MSRV32_IMG_ILLEGAL_EN defined:
//    Adds port illegal_out (out, 1), stored per entry and reset to 0.
//    imm_type 7 stores imm=0 and illegal=1.
//  MSRV32_IMG_ILLEGAL_EN undefined:
//    No illegal_out port; imm_type 7 decodes as I-type.
// STRUCTURE
//  Package msrv32_img_pkg holds:
//    imm-type localparams (R_TYPE..CSR_TYPE, RSVD_TYPE=3'd7)
//    function imm_decode(instr, type) returning a 64-bit immediate, truncated to XLEN.
//  Sub-module msrv32_img_fifo: generic DEPTH x W synchronous FIFO with flush, count, full and empty.
//    The top level is the decode function plus FIFO instance.
// TESTING
//  I-type: instr 0xFFF00093 type 1 -> imm_out 0xFFFFFFFF; with XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
//  B-type and U-type:
//    0xFE000EE3 type 3 -> 0xFFFFFFFC.
//    0x123450B7 type 4 -> 0x12345000.
//    XLEN=64, 0x800000B7 type 4 -> 0xFFFFFFFF80000000.
//  CSR: 0x000FD073 type 6 -> 0x0000001F.
//    J-type: 0xFFDFF06F type 5 -> 0xFFFFFFFC.
//  Backpressure, DEPTH=2:
//    Hold ready_in=0 and push 3 tags A,B,C.
//    Expect A and B accepted, ready_out=0, count_out=2, C held.
//    Release ready_in: A, B, C pop in order, one per cycle.
//  Simultaneous push and pop at count 1 keeps count 1 with order preserved. Flush with valid_in=1 gives count 0 next cycle.
//    The flushed input is never output.
//  Reset and illegal type:
//    Assert rst_n_in low while count=2: valid_out drops without waiting for a clock edge, and all outputs are 0.
//    Type 7 with the macro defined: imm 0, illegal_out=1.
//    Type 7 without the macro: I-type result.

Source files
------------

// File: rtl/msrv32_img_pkg.sv
// Immediate-type encodings and the shared immediate decoder for msrv32_img_pipe.
// Optional feature macro: MSRV32_IMG_ILLEGAL_EN (reserved type decodes to zero instead of I-type).
package msrv32_img_pkg;

    localparam logic [2:0] R_TYPE    = 3'd0;
    localparam logic [2:0] I_TYPE    = 3'd1;
    localparam logic [2:0] S_TYPE    = 3'd2;
    localparam logic [2:0] B_TYPE    = 3'd3;
    localparam logic [2:0] U_TYPE    = 3'd4;
    localparam logic [2:0] J_TYPE    = 3'd5;
    localparam logic [2:0] CSR_TYPE  = 3'd6;
    localparam logic [2:0] RSVD_TYPE = 3'd7;

    // instr holds instruction bits [31:7], so instruction bit k sits at instr[k-7].
    function automatic logic [63:0] imm_decode(input logic [24:0] instr,
                                               input logic [2:0]  imm_type);
        logic [63:0] imm;
        case (imm_type)
            S_TYPE:   imm = {{52{instr[24]}}, instr[24:18], instr[4:0]};
            B_TYPE:   imm = {{52{instr[24]}}, instr[0], instr[23:18], instr[4:1], 1'b0};
            U_TYPE:   imm = {{32{instr[24]}}, instr[24:5], 12'h000};
            J_TYPE:   imm = {{44{instr[24]}}, instr[12:5], instr[13], instr[23:14], 1'b0};
            CSR_TYPE: imm = {59'd0, instr[12:8]};
`ifdef MSRV32_IMG_ILLEGAL_EN
            RSVD_TYPE: imm = 64'd0;
`endif
            default:  imm = {{52{instr[24]}}, instr[24:13]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/msrv32_img_fifo.sv
// Generic DEPTH x W synchronous FIFO with flush and occupancy count; head data reads as zero when empty.
// Used by msrv32_img_pipe (feature macro MSRV32_IMG_ILLEGAL_EN only widens the entry).
module msrv32_img_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    import msrv32_img_pkg::*;

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Flush outranks push/pop; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/msrv32_img_pipe.sv
// Immediate generator: decodes each accepted instruction and queues imm/type/tag for register read.
// Define MSRV32_IMG_ILLEGAL_EN to add illegal_out and zero the immediate of reserved-type instructions.
module msrv32_img_pipe
    import msrv32_img_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   flush_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [24:0]            instr_in,
    input  logic [2:0]             imm_type_in,
    input  logic [TAG_W-1:0]       tag_in,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [XLEN-1:0]        imm_out,
    output logic [2:0]             imm_type_out,
    output logic [TAG_W-1:0]       tag_out,
    output logic [$clog2(DEPTH):0] count_out
`ifdef MSRV32_IMG_ILLEGAL_EN
    ,
    output logic                   illegal_out
`endif
);

`ifdef MSRV32_IMG_ILLEGAL_EN
    localparam int ENT_W = XLEN + 3 + TAG_W + 1;
`else
    localparam int ENT_W = XLEN + 3 + TAG_W;
`endif

    logic [XLEN-1:0]  w_imm;
    logic [ENT_W-1:0] w_wr_ent;
    logic [ENT_W-1:0] w_rd_ent;
    logic             w_full;
    logic             w_empty;

    assign w_imm = XLEN'(imm_decode(instr_in, imm_type_in));

`ifdef MSRV32_IMG_ILLEGAL_EN
    assign w_wr_ent = {(imm_type_in == RSVD_TYPE), imm_type_in, tag_in, w_imm};
    assign {illegal_out, imm_type_out, tag_out, imm_out} = w_rd_ent;
`else
    assign w_wr_ent = {imm_type_in, tag_in, w_imm};
    assign {imm_type_out, tag_out, imm_out} = w_rd_ent;
`endif

    assign ready_out = ~w_full;
    assign valid_out = ~w_empty;

    msrv32_img_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_flush (flush_in),
        .i_push  (valid_in),
        .i_pop   (ready_in),
        .i_data  (w_wr_ent),
        .o_data  (w_rd_ent),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count_out)
    );

endmodule

// File: tb/tb_msrv32_img_pipe.sv
// Bench for msrv32_img_pipe: directed decode/backpressure/flush/reset steps, then randomized traffic vs. a queue model.
// Honours MSRV32_IMG_ILLEGAL_EN when defined.
module tb_msrv32_img_pipe;

`ifdef MSRV32_IMG_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif
    localparam int DA = 2;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        va = 1'b0, vb = 1'b0, ra = 1'b0, rb = 1'b0;
    logic [24:0] instr = '0;
    logic [2:0]  itype = '0;
    logic [31:0] tag = '0;

    logic        a_rdy, a_vld, b_rdy, b_vld;
    logic [31:0] a_imm;
    logic [63:0] b_imm;
    logic [2:0]  a_typ, b_typ;
    logic [31:0] a_tag;
    logic [15:0] b_tag;
    logic [1:0]  a_cnt;
    logic [2:0]  b_cnt;
    logic        a_ill, b_ill;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  t;
        logic [31:0] tag;
        logic        ill;
    } ent_t;
    ent_t qa[$];
    ent_t qb[$];

    always #5 clk = ~clk;

    msrv32_img_pipe #(.XLEN(32), .DEPTH(DA), .TAG_W(32)) u_a (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(va), .ready_out(a_rdy),
        .instr_in(instr), .imm_type_in(itype), .tag_in(tag), .valid_out(a_vld), .ready_in(ra),
        .imm_out(a_imm), .imm_type_out(a_typ), .tag_out(a_tag), .count_out(a_cnt)
`ifdef MSRV32_IMG_ILLEGAL_EN
        , .illegal_out(a_ill)
`endif
    );

    msrv32_img_pipe #(.XLEN(64), .DEPTH(DB), .TAG_W(16)) u_b (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(vb), .ready_out(b_rdy),
        .instr_in(instr), .imm_type_in(itype), .tag_in(tag[15:0]), .valid_out(b_vld), .ready_in(rb),
        .imm_out(b_imm), .imm_type_out(b_typ), .tag_out(b_tag), .count_out(b_cnt)
`ifdef MSRV32_IMG_ILLEGAL_EN
        , .illegal_out(b_ill)
`endif
    );

`ifndef MSRV32_IMG_ILLEGAL_EN
    assign a_ill = 1'b0;
    assign b_ill = 1'b0;
`endif

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    // Reference immediate computed with signed arithmetic on the full 32-bit word.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] t);
        longint      x;
        logic [63:0] r;
        x = longint'($signed(ins));
        case (t)
            3'd2: r = 64'((x >>> 25) << 5) | 64'(ins[11:7]);
            3'd3: r = 64'((x >>> 31) << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
                      | (64'(ins[11:8]) << 1);
            3'd4: r = 64'(x) & ~64'hFFF;
            3'd5: r = 64'((x >>> 31) << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
                      | (64'(ins[30:21]) << 1);
            3'd6: r = 64'(ins[19:15]);
            3'd7: r = ILL_EN ? 64'd0 : 64'(x >>> 20);
            default: r = 64'(x >>> 20);
        endcase
        return r;
    endfunction

    task automatic check_model();
        chk("a_valid", a_vld, qa.size() != 0);
        chk("a_ready", a_rdy, qa.size() < DA);
        chk("a_count", a_cnt, qa.size());
        if (qa.size() != 0) begin
            chk("a_imm", a_imm, qa[0].imm[31:0]);
            chk("a_type", a_typ, qa[0].t);
            chk("a_tag", a_tag, qa[0].tag);
            if (ILL_EN) chk("a_ill", a_ill, qa[0].ill);
        end
        chk("b_valid", b_vld, qb.size() != 0);
        chk("b_ready", b_rdy, qb.size() < DB);
        chk("b_count", b_cnt, qb.size());
        if (qb.size() != 0) begin
            chk("b_imm", b_imm, qb[0].imm);
            chk("b_type", b_typ, qb[0].t);
            chk("b_tag", b_tag, qb[0].tag[15:0]);
            if (ILL_EN) chk("b_ill", b_ill, qb[0].ill);
        end
    endtask

    task automatic step_model();
        ent_t e;
        logic pa, pb, oa, ob;
        e.imm = ref_imm({instr, 7'b0}, itype);
        e.t   = itype;
        e.tag = tag;
        e.ill = ILL_EN && (itype == 3'd7);
        if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            pa = va && (qa.size() < DA);
            oa = ra && (qa.size() > 0);
            pb = vb && (qb.size() < DB);
            ob = rb && (qb.size() > 0);
            if (oa) qa.delete(0);
            if (pa) qa.push_back(e);
            if (ob) qb.delete(0);
            if (pb) qb.push_back(e);
        end
    endtask

    task automatic dir_imm(input string nm, input logic [31:0] ins, input logic [2:0] t,
                           input logic [63:0] e32, input logic [63:0] e64, input logic eill);
        @(negedge clk);
        instr = ins[31:7]; itype = t; tag = $urandom(); va = 1'b1; vb = 1'b1; ra = 1'b0; rb = 1'b0;
        #1 chk({nm, "_nofallthru"}, a_vld, 1'b0);
        @(negedge clk);
        va = 1'b0; vb = 1'b0;
        chk({nm, "_imm32"}, a_imm, e32);
        chk({nm, "_imm64"}, b_imm, e64);
        chk({nm, "_type"}, a_typ, t);
        chk({nm, "_tag"}, a_tag, tag);
        if (ILL_EN) chk({nm, "_ill"}, a_ill, eill);
        ra = 1'b1; rb = 1'b1;
        @(negedge clk);
        ra = 1'b0; rb = 1'b0;
        chk({nm, "_popped"}, {a_vld, b_vld}, 2'b00);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", {a_vld, b_vld}, 2'b00);
        chk("rst_ready", {a_rdy, b_rdy}, 2'b11);
        chk("rst_count", {a_cnt, b_cnt}, 5'd0);
        chk("rst_imm", a_imm, 64'd0);
        chk("rst_tag", a_tag, 64'd0);
        chk("rst_type", a_typ, 64'd0);
        rst_n = 1'b1;

        dir_imm("I",   32'hFFF00093, 3'd1, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        dir_imm("B",   32'hFE000EE3, 3'd3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        dir_imm("U",   32'h123450B7, 3'd4, 64'h12345000, 64'h0000000012345000, 1'b0);
        dir_imm("U64", 32'h800000B7, 3'd4, 64'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        dir_imm("CSR", 32'h000FD073, 3'd6, 64'h0000001F, 64'h000000000000001F, 1'b0);
        dir_imm("J",   32'hFFDFF06F, 3'd5, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        dir_imm("S",   32'hFE112E23, 3'd2, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        dir_imm("R",   32'h00208033, 3'd0, 64'h00000002, 64'h0000000000000002, 1'b0);
        dir_imm("RSVD", 32'hFFF00093, 3'd7, ILL_EN ? 64'd0 : 64'hFFFFFFFF,
                ILL_EN ? 64'd0 : 64'hFFFFFFFFFFFFFFFF, ILL_EN);

        // Backpressure on the depth-2 instance
        @(negedge clk);
        ra = 1'b0; va = 1'b1; itype = 3'd1; instr = '0; tag = 32'hA;
        @(negedge clk);
        tag = 32'hB;
        chk("bp_cnt1", a_cnt, 2'd1);
        @(negedge clk);
        tag = 32'hC;
        chk("bp_cnt2", a_cnt, 2'd2);
        chk("bp_ready0", a_rdy, 1'b0);
        chk("bp_headA", a_tag, 32'hA);
        @(negedge clk);
        chk("bp_hold_cnt", a_cnt, 2'd2);
        chk("bp_hold_headA", a_tag, 32'hA);
        ra = 1'b1;
        @(negedge clk);
        chk("bp_headB", a_tag, 32'hB);
        chk("bp_cnt_after_A", a_cnt, 2'd1);
        @(negedge clk);
        va = 1'b0;
        chk("simul_headC", a_tag, 32'hC);
        chk("simul_cnt", a_cnt, 2'd1);
        @(negedge clk);
        ra = 1'b0;
        chk("bp_drained_cnt", a_cnt, 2'd0);
        chk("bp_drained_vld", a_vld, 1'b0);

        // Flush with a valid input present
        @(negedge clk);
        va = 1'b1; tag = 32'h1111;
        @(negedge clk);
        chk("fl_pre_cnt", a_cnt, 2'd1);
        flush = 1'b1; tag = 32'h2222;
        @(negedge clk);
        flush = 1'b0; va = 1'b0;
        chk("fl_cnt", a_cnt, 2'd0);
        chk("fl_vld", a_vld, 1'b0);
        @(negedge clk);
        chk("fl_dropped_vld", a_vld, 1'b0);
        chk("fl_dropped_cnt", a_cnt, 2'd0);

        // Asynchronous reset while both FIFOs hold entries
        @(negedge clk);
        va = 1'b1; vb = 1'b1; itype = 3'd1; instr = '1; tag = 32'h5A5A5A5A;
        @(negedge clk);
        @(negedge clk);
        va = 1'b0; vb = 1'b0;
        chk("ar_pre_cnt", a_cnt, 2'd2);
        chk("ar_pre_vld", a_vld, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vld", {a_vld, b_vld}, 2'b00);
        chk("ar_cnt", {a_cnt, b_cnt}, 5'd0);
        chk("ar_imm", {a_imm, b_imm}, 96'd0);
        chk("ar_tag", {a_tag, b_tag}, 48'd0);
        chk("ar_type", {a_typ, b_typ}, 6'd0);
        chk("ar_ready", {a_rdy, b_rdy}, 2'b11);
        if (ILL_EN) chk("ar_ill", {a_ill, b_ill}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        qa.delete();
        qb.delete();

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            check_model();
            va    = 1'($urandom_range(0, 1));
            vb    = 1'($urandom_range(0, 1));
            ra    = ($urandom_range(0, 3) != 0);
            rb    = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 24) == 0);
            instr = 25'($urandom());
            itype = 3'($urandom_range(0, 7));
            tag   = $urandom();
            step_model();
        end
        @(negedge clk);
        check_model();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
